// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Holds the in-flight tag format and the forward-select width function.
package fwd_pkg;

  // Tag dst is sized for the widest supported register address.
  // Narrower addresses are zero-extended when stored or compared.
  localparam int TAG_DST_W = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic                 is_load;
    logic [TAG_DST_W-1:0] dst;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_BUBBLE = '0;

  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Destination-tag shift register: entry 0 is the instruction in EX,
// entry k is k stages past EX; the oldest entry falls off each cycle.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  fwd_tag_t             in_tag,
  output fwd_tag_t [DEPTH:0]   tags
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tags <= {(DEPTH + 1){TAG_BUBBLE}};
    end else begin
      tags <= {tags[DEPTH-1:0], in_tag};
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit with its own tag pipeline.
// Stall is combinational; forward selects are registered for the EX stage.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 3,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = fwd_sel_w(FWD_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_use,
  input  logic [REG_ADDR_W-1:0]         id_dst,
  input  logic                          id_wr,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [15:0]                   stall_cycles
);

  fwd_tag_t [FWD_DEPTH:0]          tags;
  fwd_tag_t                        id_tag;
  logic [NUM_SRC-1:0][FWD_DEPTH:0] match;
  logic                            hazard;
  logic                            issue;
  logic [NUM_SRC*SEL_W-1:0]        sel_next;

  fwd_tag_pipe #(.DEPTH(FWD_DEPTH)) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_tag (id_tag),
    .tags   (tags)
  );

  // Live match of each ID operand against every in-flight tag.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j <= FWD_DEPTH; j++) begin
        match[i][j] = id_use[i]
                    && (id_src[i*REG_ADDR_W +: REG_ADDR_W] != '0)
                    && tags[j].valid && tags[j].wr
                    && (tags[j].dst == TAG_DST_W'(id_src[i*REG_ADDR_W +: REG_ADDR_W]));
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (match[i][j] && tags[j].is_load) hazard = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites last.
  always_comb begin
    sel_next = {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (match[i][j]) sel_next[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
      end
    end
  end

  assign stall = id_valid & ~flush & hazard & ~rst;
  assign issue = id_valid & ~flush & ~hazard;

  always_comb begin
    id_tag = TAG_BUBBLE;
    if (issue) begin
      id_tag.valid   = 1'b1;
      id_tag.wr      = id_wr;
      id_tag.is_load = id_is_load;
      id_tag.dst     = TAG_DST_W'(id_dst);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel <= {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
    end else if (issue) begin
      fwd_sel <= sel_next;
    end else begin
      fwd_sel <= {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It replaces the purely combinational forward-select logic with a unit that owns its own in-flight destination-tag pipeline. It generates registered forward selects for a configurable number of source operands and a configurable forwarding depth. It also detects load-use hazards, stalls the ID stage for the exact number of cycles needed, inserts bubbles, and counts stall cycles.

## Interface
Parameters:
- REG_ADDR_W, 3, register-address width; register 0 is hard-wired zero.
- NUM_SRC, 3, source operands per instruction (A, B, store data).
- FWD_DEPTH, 2, number of post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, …).
- LOAD_LAT, 1, extra stages after EX before a load result can be forwarded; must be < FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1), derived; width of one forward select.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; operand i is bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_use  in  NUM_SRC  bit i set when operand i is read from the register file (clear for immediates).
- id_dst  in  REG_ADDR_W  destination register.
- id_wr  in  1  instruction writes id_dst.
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill the ID instruction this cycle.
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- fwd_sel  out  NUM_SRC*SEL_W  registered; per operand of the instruction in EX: 0 = register file, k = stage k result.
- stall_cycles  out  16  saturating count of cycles with stall=1.

## Operation
- Tag pipeline: entries T[0..FWD_DEPTH], each {valid, wr, is_load, dst}. T[0] is the instruction in EX; T[k] is the instruction k stages past EX.
- Every cycle T[k] <= T[k-1] for k ≥ 1; the oldest entry retires.
- Issue: when id_valid & !stall & !flush, T[0] <= ID tag. Otherwise T[0] <= bubble (valid=0).
- Live match of operand i against T[j]: id_use[i], id_src[i] != 0, T[j].valid, T[j].wr, and T[j].dst == id_src[i].
- Load-use hazard: any live match with T[j].is_load and j < LOAD_LAT.
- stall = id_valid & !flush & hazard. rst forces stall=0.
- Forward select, computed at issue and registered: for each operand, choose the smallest j in 0..FWD_DEPTH-1 with a live match, and set fwd_sel <= j+1 (the stage the producer occupies next cycle). With no match, fwd_sel <= 0.
- The youngest producer always wins. Producers that have retired past FWD_DEPTH are served by the register file, which writes before it reads.
- When nothing issues (bubble, stall, or flush), fwd_sel <= 0.
- stall_cycles increments when stall=1 and holds at 0xFFFF.
- Reset: all T[k].valid=0, fwd_sel=0, stall_cycles=0.

## Timing
- Stall decision is same-cycle (combinational from ID inputs and T); forward selects are valid during the consumer's EX cycle.
- A consumer whose load producer sits in T[j] stalls for LOAD_LAT-j cycles, then issues with fwd_sel = LOAD_LAT+1.
- flush and stall in the same cycle: flush wins, stall=0, a bubble enters T[0], and stall_cycles does not increment.
- Reset mid-stall: the next cycle has empty tags, so stall=0.
- id_valid=0 never stalls and never matches.

## Structure
- Package fwd_pkg holds the tag struct type, the constant FWD_SEL_RF=0, and a function fwd_sel_w(depth).
- One sub-module, fwd_tag_pipe: the FWD_DEPTH+1-entry shift register with bubble insert and reset.
- The top level holds the compare/priority logic, the output registers and the counter.

All scenarios use the defaults: REG_ADDR_W=3, NUM_SRC=3, FWD_DEPTH=2, LOAD_LAT=1.

## Test plan
- **ALU → ALU back-to-back:** `add r1` issued, then `sub r2,r1,r3` → no stall; in sub's EX cycle fwd_sel[A]=1, fwd_sel[B]=0.
- **ALU, independent, consumer:** `add r1`, independent, then `or r4,r5,r1` → fwd_sel[B]=2. With two independent instructions in between, fwd_sel[B]=0.
- **Load-use:** `lw r1`, then `add r2,r1,r1` → stall=1 for exactly 1 cycle; T[0] is a bubble; add's fwd_sel[A]=fwd_sel[B]=2; stall_cycles=1.
- **Register 0 and immediates:** `add r0`, then `add r2,r0,r0`; and `lw r1`, then an immediate-B consumer with id_use[B]=0 and id_src[B]=1 → no stall, all selects 0.
- **Double producer, store data:** `add r1`, `lw r1`, then `sw r1` using operand 2 → stall 1 cycle (the youngest producer is the load), then fwd_sel[2]=2.
- **Flush and reset:** flush during a load-use stall → stall=0 and the counter unchanged. rst asserted with a load in T[0] → next cycle stall=0, fwd_sel=0, stall_cycles=0. Force 70000 stall cycles → stall_cycles=0xFFFF.
